// File: rtl/ysyx_22050243_trap_ctrl.sv
// ysyx_22050243_trap_ctrl
// Trap controller at the write-back stage. It detects ecall/ebreak/mret and
// qualified machine interrupts (MEI/MSI/MTI) and picks one by fixed priority.
// It then runs a flush handshake with the pipeline, issues a one-cycle CSR
// write strobe, and finally issues a one-cycle PC redirect.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   wb_valid_i, wb_inst_i     WB stage valid flag and instruction
//   wb_pc_i, wb_next_pc_i     PC of the WB instruction and of its successor
//   irq_msip_i/mtip_i/meip_i  level interrupt pending lines
//   mstatus_i, mie_i,
//   mtvec_i, mepc_i           current CSR values, sampled at the event cycle
//   flush_ack_i               pipeline reports flush complete
//   trap_stall_o              hold WB so the instruction does not retire
//   flush_req_o               request pipeline flush
//   csr_we_o                  one-cycle CSR write strobe
//   mepc_wdata_o,
//   mcause_wdata_o,
//   mstatus_wdata_o           CSR write data, valid with csr_we_o
//   is_mret_o                 with csr_we_o: only mstatus is written
//   redirect_valid_o          one-cycle redirect strobe
//   redirect_pc_o             redirect target
//   busy_o                    sequence in progress (FSM not idle)
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | watching WB for an event; the event is latched on entry
// FLUSH    | flush_req held high until flush_ack_i
// COMMIT   | single-cycle CSR write strobe
// REDIRECT | single-cycle PC redirect strobe, then back to IDLE

module ysyx_22050243_trap_ctrl #(
    parameter int XLEN        = 64,
    parameter int INST_WIDTH  = 32,
    parameter int ECALL_CODE  = 11,
    parameter int EBREAK_CODE = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wb_valid_i,
    input  logic [INST_WIDTH-1:0] wb_inst_i,
    input  logic [XLEN-1:0]       wb_pc_i,
    input  logic [XLEN-1:0]       wb_next_pc_i,
    input  logic                  irq_msip_i,
    input  logic                  irq_mtip_i,
    input  logic                  irq_meip_i,
    input  logic [XLEN-1:0]       mstatus_i,
    input  logic [XLEN-1:0]       mie_i,
    input  logic [XLEN-1:0]       mtvec_i,
    input  logic [XLEN-1:0]       mepc_i,
    input  logic                  flush_ack_i,
    output logic                  trap_stall_o,
    output logic                  flush_req_o,
    output logic                  csr_we_o,
    output logic [XLEN-1:0]       mepc_wdata_o,
    output logic [XLEN-1:0]       mcause_wdata_o,
    output logic [XLEN-1:0]       mstatus_wdata_o,
    output logic                  is_mret_o,
    output logic                  redirect_valid_o,
    output logic [XLEN-1:0]       redirect_pc_o,
    output logic                  busy_o
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_FLUSH    = 2'd1;
    localparam logic [1:0] S_COMMIT   = 2'd2;
    localparam logic [1:0] S_REDIRECT = 2'd3;

    localparam logic [XLEN-1:0] CODE_ECALL  = XLEN'(ECALL_CODE);
    localparam logic [XLEN-1:0] CODE_EBREAK = XLEN'(EBREAK_CODE);
    localparam logic [XLEN-1:0] CODE_MEI    = XLEN'(11);
    localparam logic [XLEN-1:0] CODE_MSI    = XLEN'(3);
    localparam logic [XLEN-1:0] CODE_MTI    = XLEN'(7);

    logic [1:0]      state_q, state_d;
    logic            mret_q, mret_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mstatus_q, mstatus_d;
    logic [XLEN-1:0] tgt_q, tgt_d;

    // Instruction decode
    logic is_system, is_ecall, is_ebreak, is_mret_inst, is_exc;
    assign is_system    = wb_valid_i && (wb_inst_i[6:0] == 7'b1110011)
                          && (wb_inst_i[14:12] == 3'b000);
    assign is_ecall     = is_system && (wb_inst_i[31:20] == 12'h000);
    assign is_ebreak    = is_system && (wb_inst_i[31:20] == 12'h001);
    assign is_mret_inst = is_system && (wb_inst_i[31:20] == 12'h302);
    assign is_exc       = is_ecall || is_ebreak;

    // Interrupts ride on a valid, non-system-trap instruction so that
    // mepc (= wb_next_pc) always points at a real successor.
    logic mei_q_ok, msi_q_ok, mti_q_ok, irq_take, event_any;
    assign mei_q_ok  = irq_meip_i && mie_i[11] && mstatus_i[3];
    assign msi_q_ok  = irq_msip_i && mie_i[3]  && mstatus_i[3];
    assign mti_q_ok  = irq_mtip_i && mie_i[7]  && mstatus_i[3];
    assign irq_take  = wb_valid_i && !is_exc && !is_mret_inst
                       && (mei_q_ok || msi_q_ok || mti_q_ok);
    assign event_any = is_exc || is_mret_inst || irq_take;

    logic unused_bits;
    assign unused_bits = ^{wb_inst_i[19:15], wb_inst_i[11:7],
                           mie_i[XLEN-1:12], mie_i[10:8], mie_i[6:4], mie_i[2:0]};

    logic [XLEN-1:0] code, base, trap_ms, ret_ms;

    always_comb begin
        code = CODE_MTI;
        if (is_ecall)       code = CODE_ECALL;
        else if (is_ebreak) code = CODE_EBREAK;
        else if (mei_q_ok)  code = CODE_MEI;
        else if (msi_q_ok)  code = CODE_MSI;

        base = {mtvec_i[XLEN-1:2], 2'b00};

        trap_ms        = mstatus_i;
        trap_ms[7]     = mstatus_i[3];
        trap_ms[3]     = 1'b0;
        trap_ms[12:11] = 2'b11;

        ret_ms         = mstatus_i;
        ret_ms[3]      = mstatus_i[7];
        ret_ms[7]      = 1'b1;
        ret_ms[12:11]  = 2'b11;
    end

    always_comb begin
        state_d   = state_q;
        mret_d    = mret_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;
        mstatus_d = mstatus_q;
        tgt_d     = tgt_q;
        case (state_q)
            S_IDLE: begin
                if (event_any) begin
                    state_d = S_FLUSH;
                    if (is_exc) begin
                        mret_d    = 1'b0;
                        mepc_d    = wb_pc_i;
                        mcause_d  = code;
                        mstatus_d = trap_ms;
                        tgt_d     = base;
                    end else if (is_mret_inst) begin
                        mret_d    = 1'b1;
                        mepc_d    = '0;
                        mcause_d  = '0;
                        mstatus_d = ret_ms;
                        tgt_d     = mepc_i;
                    end else begin
                        mret_d    = 1'b0;
                        mepc_d    = wb_next_pc_i;
                        mcause_d  = {1'b1, code[XLEN-2:0]};
                        mstatus_d = trap_ms;
                        // vectored mode offsets interrupts only; wraps mod 2^XLEN
                        tgt_d     = (mtvec_i[1:0] == 2'b01)
                                    ? base + {code[XLEN-3:0], 2'b00} : base;
                    end
                end
            end
            S_FLUSH:    if (flush_ack_i) state_d = S_COMMIT;
            S_COMMIT:   state_d = S_REDIRECT;
            S_REDIRECT: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            mret_q    <= 1'b0;
            mepc_q    <= '0;
            mcause_q  <= '0;
            mstatus_q <= '0;
            tgt_q     <= '0;
        end else begin
            state_q   <= state_d;
            mret_q    <= mret_d;
            mepc_q    <= mepc_d;
            mcause_q  <= mcause_d;
            mstatus_q <= mstatus_d;
            tgt_q     <= tgt_d;
        end
    end

    assign busy_o           = (state_q != S_IDLE);
    assign flush_req_o      = (state_q == S_FLUSH);
    assign csr_we_o         = (state_q == S_COMMIT);
    assign is_mret_o        = (state_q == S_COMMIT) && mret_q;
    assign redirect_valid_o = (state_q == S_REDIRECT);
    // stall starts combinationally in the event cycle so WB never retires it
    assign trap_stall_o     = ((state_q == S_IDLE) && event_any)
                              || (state_q == S_FLUSH) || (state_q == S_COMMIT);
    assign mepc_wdata_o     = mepc_q;
    assign mcause_wdata_o   = mcause_q;
    assign mstatus_wdata_o  = mstatus_q;
    assign redirect_pc_o    = tgt_q;

endmodule
